// File: rtl/dbus_initiator.sv
// Wishbone dbus initiator: runs single reads/writes or paired 64-bit reads on the
// peripheral bus from a valid/ready request port, with an ack timeout.
module dbus_initiator #(
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_adr,
  input  logic [31:0] req_dat,
  input  logic        req_we,
  input  logic        req_pair,
  output logic        rsp_valid,
  output logic [63:0] rsp_dat,
  output logic        rsp_err,
  output logic [31:0] wb_dbus_adr,
  output logic [31:0] wb_dbus_dat,
  output logic        wb_dbus_we,
  output logic        wb_dbus_cyc,
  input  logic [31:0] wb_dbus_rdt,
  input  logic        wb_dbus_ack
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam bit          TO_EN = (TIMEOUT != 0);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic [31:0]   base_adr;
  logic [31:0]   base_dat;
  logic          base_we;
  logic          pair;
  logic          beat;
  logic [TW-1:0] tcnt;

  logic          to_hit;

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_DONE);
  // Counter about to reach TIMEOUT on this edge; ack in the same cycle still wins.
  assign to_hit    = TO_EN && (tcnt == TLAST);

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state       <= S_IDLE;
      base_adr    <= 32'h0;
      base_dat    <= 32'h0;
      base_we     <= 1'b0;
      pair        <= 1'b0;
      beat        <= 1'b0;
      tcnt        <= '0;
      rsp_dat     <= 64'h0;
      rsp_err     <= 1'b0;
      wb_dbus_adr <= 32'h0;
      wb_dbus_dat <= 32'h0;
      wb_dbus_we  <= 1'b0;
      wb_dbus_cyc <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            base_adr    <= req_adr;
            base_dat    <= req_dat;
            base_we     <= req_we;
            pair        <= req_pair & ~req_we;
            beat        <= 1'b0;
            tcnt        <= '0;
            rsp_dat     <= 64'h0;
            rsp_err     <= 1'b0;
            wb_dbus_adr <= req_adr;
            wb_dbus_dat <= req_dat;
            wb_dbus_we  <= req_we;
            wb_dbus_cyc <= 1'b1;
            state       <= S_BUS;
          end
        end
        S_BUS: begin
          if (wb_dbus_ack) begin
            if (!base_we) begin
              if (beat) rsp_dat[63:32] <= wb_dbus_rdt;
              else      rsp_dat[31:0]  <= wb_dbus_rdt;
            end
            wb_dbus_cyc <= 1'b0;
            wb_dbus_adr <= 32'h0;
            wb_dbus_dat <= 32'h0;
            wb_dbus_we  <= 1'b0;
            state       <= (pair && !beat) ? S_GAP : S_DONE;
          end else begin
            tcnt <= tcnt + 1'b1;
            if (to_hit) begin
              // Abandon the transaction; any beat already captured is kept.
              wb_dbus_cyc <= 1'b0;
              wb_dbus_adr <= 32'h0;
              wb_dbus_dat <= 32'h0;
              wb_dbus_we  <= 1'b0;
              rsp_err     <= 1'b1;
              state       <= S_DONE;
            end
          end
        end
        S_GAP: begin
          // One idle cycle lets chip_select re-arm before the high word.
          beat        <= 1'b1;
          tcnt        <= '0;
          wb_dbus_adr <= base_adr + 32'd4;
          wb_dbus_dat <= base_dat;
          wb_dbus_we  <= 1'b0;
          wb_dbus_cyc <= 1'b1;
          state       <= S_BUS;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_initiator.sv
// Bench for dbus_initiator: small timer/register/ROM peripheral model, scoreboard of
// expected responses, and per-scenario tasks.
module tb_dbus_initiator;

  logic        wb_clk = 1'b0;
  logic        wb_rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_adr = 32'h0;
  logic [31:0] req_dat = 32'h0;
  logic        req_we = 1'b0;
  logic        req_pair = 1'b0;
  logic        rsp_valid;
  logic [63:0] rsp_dat;
  logic        rsp_err;
  logic [31:0] wb_dbus_adr;
  logic [31:0] wb_dbus_dat;
  logic        wb_dbus_we;
  logic        wb_dbus_cyc;
  logic [31:0] wb_dbus_rdt = 32'h0;
  logic        wb_dbus_ack = 1'b0;

  dbus_initiator #(.TIMEOUT(16), .TW(8)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_adr(req_adr),
    .req_dat(req_dat), .req_we(req_we), .req_pair(req_pair),
    .rsp_valid(rsp_valid), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .wb_dbus_adr(wb_dbus_adr), .wb_dbus_dat(wb_dbus_dat), .wb_dbus_we(wb_dbus_we),
    .wb_dbus_cyc(wb_dbus_cyc), .wb_dbus_rdt(wb_dbus_rdt), .wb_dbus_ack(wb_dbus_ack)
  );

  always #5 wb_clk = ~wb_clk;

  typedef struct {
    logic [63:0] dat;
    logic        err;
  } rsp_t;

  rsp_t sb[$];
  rsp_t obs[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Peripheral model: timer at c0000000/4 (frozen), register at c0000008, ROM at ffxxxxxx.
  logic [63:0] mtime = 64'h12345678_fffffff0;
  logic [31:0] reg8 = 32'h0;
  int          ack_lat = 1;
  int          ack_cnt = 0;

  always @(posedge wb_clk) begin
    wb_dbus_ack <= 1'b0;
    wb_dbus_rdt <= 32'h0;
    if (wb_dbus_cyc && !wb_dbus_ack &&
        (wb_dbus_adr[31:24] == 8'hc0 || wb_dbus_adr[31:24] == 8'hff)) begin
      if (ack_cnt >= ack_lat) begin
        ack_cnt     <= 0;
        wb_dbus_ack <= 1'b1;
        if (wb_dbus_we) begin
          if (wb_dbus_adr == 32'hc0000008) reg8 <= wb_dbus_dat;
        end else begin
          case (wb_dbus_adr)
            32'hc0000000: wb_dbus_rdt <= mtime[31:0];
            32'hc0000004: wb_dbus_rdt <= mtime[63:32];
            32'hc0000008: wb_dbus_rdt <= reg8;
            default:      wb_dbus_rdt <= 32'hcafef00d;
          endcase
        end
      end else begin
        ack_cnt <= ack_cnt + 1;
      end
    end else if (!wb_dbus_cyc) begin
      ack_cnt <= 0;
    end
  end

  // Observation: responses, cyc rising edges, bus-protocol violations, accepts.
  int          n_rise = 0;
  int          prot_bad = 0;
  int          acc_cnt = 0;
  logic        prev_cyc = 1'b0;
  logic [31:0] hold_adr = 32'h0;

  always @(negedge wb_clk) begin
    if (!wb_rst && rsp_valid) obs.push_back('{rsp_dat, rsp_err});
    if (wb_dbus_cyc === 1'b1 && !prev_cyc) n_rise = n_rise + 1;
    if (!wb_rst && wb_dbus_cyc === 1'b0 &&
        (wb_dbus_adr !== 32'h0 || wb_dbus_dat !== 32'h0 || wb_dbus_we !== 1'b0))
      prot_bad = prot_bad + 1;
    if (wb_dbus_cyc === 1'b1 && prev_cyc && wb_dbus_adr !== hold_adr) prot_bad = prot_bad + 1;
    hold_adr = wb_dbus_adr;
    prev_cyc = (wb_dbus_cyc === 1'b1);
  end

  always @(posedge wb_clk)
    if (!wb_rst && req_valid && req_ready) acc_cnt = acc_cnt + 1;

  initial begin
    repeat (50000) @(posedge wb_clk);
    $display("FAIL watchdog: bench did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic we,
                       input logic pr, input logic [63:0] ed, input logic ee);
    int t = 0;
    @(negedge wb_clk);
    while (!req_ready && t < 200) begin @(negedge wb_clk); t++; end
    if (!req_ready) begin
      n_vec++; n_err++;
      $display("FAIL issue_ready got ready=%b want 1", req_ready);
    end else begin
      sb.push_back('{ed, ee});
      req_adr = a; req_dat = d; req_we = we; req_pair = pr; req_valid = 1'b1;
      @(negedge wb_clk);
      req_valid = 1'b0;
    end
  endtask

  task automatic wait_rsps();
    int t = 0;
    while (obs.size() < sb.size() && t < 400) begin @(negedge wb_clk); t++; end
    repeat (3) @(negedge wb_clk);
  endtask

  task automatic test_reset();
    wb_rst = 1'b1;
    repeat (3) @(negedge wb_clk);
    n_vec++;
    if ({req_ready, rsp_valid, rsp_err, wb_dbus_cyc, wb_dbus_we} !== 5'b10000) begin
      n_err++;
      $display("FAIL reset_ctl got rdy/vld/err/cyc/we=%b want 10000",
               {req_ready, rsp_valid, rsp_err, wb_dbus_cyc, wb_dbus_we});
    end
    n_vec++;
    if (rsp_dat !== 64'h0) begin n_err++; $display("FAIL reset_rsp_dat got %h want 0", rsp_dat); end
    n_vec++;
    if ({wb_dbus_adr, wb_dbus_dat} !== 64'h0) begin
      n_err++; $display("FAIL reset_bus got adr=%h dat=%h want 0", wb_dbus_adr, wb_dbus_dat);
    end
    wb_rst = 1'b0;
    @(negedge wb_clk);
  endtask

  task automatic test_write_read();
    rsp_t e, o;
    int r0 = n_rise;
    int t = 0;
    ack_lat = 1;
    issue(32'hc0000008, 32'h12341234, 1'b1, 1'b0, 64'h0, 1'b0);
    issue(32'hc0000008, 32'h0, 1'b0, 1'b0, 64'h00000000_12341234, 1'b0);
    n_vec++;
    if (wb_dbus_cyc !== 1'b1) begin n_err++; $display("FAIL wr_cyc_latency got cyc=%b want 1", wb_dbus_cyc); end
    while (wb_dbus_ack !== 1'b1 && t < 50) begin @(negedge wb_clk); t++; end
    @(negedge wb_clk);
    n_vec++;
    if ({rsp_valid, wb_dbus_cyc} !== 2'b10) begin
      n_err++; $display("FAIL wr_rsp_latency got vld/cyc=%b want 10", {rsp_valid, wb_dbus_cyc});
    end
    wait_rsps();
    while (sb.size() > 0) begin
      e = sb.pop_front(); n_vec++;
      if (obs.size() == 0) begin n_err++; $display("FAIL wr_rsp missing, want dat=%h err=%b", e.dat, e.err); end
      else begin
        o = obs.pop_front();
        if (o.dat !== e.dat || o.err !== e.err) begin
          n_err++; $display("FAIL wr_rsp got dat=%h err=%b want dat=%h err=%b", o.dat, o.err, e.dat, e.err);
        end
      end
    end
    n_vec++;
    if (n_rise - r0 !== 2) begin n_err++; $display("FAIL wr_cyc_count got %0d want 2", n_rise - r0); end
  endtask

  task automatic test_pair();
    rsp_t e, o;
    int t = 0;
    int gap = 0;
    mtime = 64'h12345678_fffffffd;
    ack_lat = 2;
    issue(32'hc0000000, 32'h0, 1'b0, 1'b1, 64'h12345678_fffffffd, 1'b0);
    while (wb_dbus_cyc === 1'b1 && t < 50) begin @(negedge wb_clk); t++; end
    while (wb_dbus_cyc !== 1'b1 && gap < 10) begin @(negedge wb_clk); gap++; end
    n_vec++;
    if (gap !== 1) begin n_err++; $display("FAIL pair_gap got %0d want 1", gap); end
    n_vec++;
    if (wb_dbus_adr !== 32'hc0000004) begin n_err++; $display("FAIL pair_adr2 got %h want c0000004", wb_dbus_adr); end
    wait_rsps();
    while (sb.size() > 0) begin
      e = sb.pop_front(); n_vec++;
      if (obs.size() == 0) begin n_err++; $display("FAIL pair_rsp missing, want dat=%h err=%b", e.dat, e.err); end
      else begin
        o = obs.pop_front();
        if (o.dat !== e.dat || o.err !== e.err) begin
          n_err++; $display("FAIL pair_rsp got dat=%h err=%b want dat=%h err=%b", o.dat, o.err, e.dat, e.err);
        end
      end
    end
  endtask

  task automatic test_timeout();
    rsp_t e, o;
    int hi = 0;
    ack_lat = 1;
    issue(32'h00000000, 32'h0, 1'b0, 1'b0, 64'h0, 1'b1);
    while (wb_dbus_cyc === 1'b1 && hi < 100) begin hi++; @(negedge wb_clk); end
    n_vec++;
    if (hi !== 16) begin n_err++; $display("FAIL to_cyc_len got %0d want 16", hi); end
    n_vec++;
    if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL to_rsp_latency got vld=%b want 1", rsp_valid); end
    ack_lat = 14;
    issue(32'hc0000008, 32'h0, 1'b0, 1'b0, 64'h00000000_12341234, 1'b0);
    wait_rsps();
    ack_lat = 15;
    issue(32'hc0000008, 32'h0, 1'b0, 1'b0, 64'h0, 1'b1);
    wait_rsps();
    while (sb.size() > 0) begin
      e = sb.pop_front(); n_vec++;
      if (obs.size() == 0) begin n_err++; $display("FAIL to_rsp missing, want dat=%h err=%b", e.dat, e.err); end
      else begin
        o = obs.pop_front();
        if (o.dat !== e.dat || o.err !== e.err) begin
          n_err++; $display("FAIL to_rsp got dat=%h err=%b want dat=%h err=%b", o.dat, o.err, e.dat, e.err);
        end
      end
    end
    ack_lat = 1;
  endtask

  task automatic test_reset_mid();
    rsp_t e, o;
    issue(32'h00000000, 32'h0, 1'b0, 1'b0, 64'h0, 1'b0);
    void'(sb.pop_back());
    repeat (3) @(negedge wb_clk);
    n_vec++;
    if (wb_dbus_cyc !== 1'b1) begin n_err++; $display("FAIL rst_mid_pre got cyc=%b want 1", wb_dbus_cyc); end
    wb_rst = 1'b1;
    repeat (2) @(negedge wb_clk);
    n_vec++;
    if ({wb_dbus_cyc, rsp_valid, req_ready} !== 3'b001) begin
      n_err++; $display("FAIL rst_mid got cyc/vld/rdy=%b want 001", {wb_dbus_cyc, rsp_valid, req_ready});
    end
    wb_rst = 1'b0;
    repeat (6) @(negedge wb_clk);
    n_vec++;
    if (obs.size() !== 0) begin n_err++; $display("FAIL rst_mid_rsp got %0d pulses want 0", obs.size()); end
    obs.delete();
    issue(32'hc0000008, 32'h0, 1'b0, 1'b0, 64'h00000000_12341234, 1'b0);
    wait_rsps();
    while (sb.size() > 0) begin
      e = sb.pop_front(); n_vec++;
      if (obs.size() == 0) begin n_err++; $display("FAIL rst_mid_next missing, want dat=%h err=%b", e.dat, e.err); end
      else begin
        o = obs.pop_front();
        if (o.dat !== e.dat || o.err !== e.err) begin
          n_err++; $display("FAIL rst_mid_next got dat=%h err=%b want dat=%h err=%b", o.dat, o.err, e.dat, e.err);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    rsp_t e, o;
    logic [31:0] ra[3] = '{32'hc0000008, 32'hc0000008, 32'hc0000000};
    logic        rw[3] = '{1'b1, 1'b0, 1'b0};
    logic        rp[3] = '{1'b0, 1'b0, 1'b1};
    logic [63:0] ed[3] = '{64'h0, 64'h00000000_a5a50001, 64'h12345678_fffffffd};
    int a0 = acc_cnt;
    int np = 0;
    @(negedge wb_clk);
    for (int i = 0; i < 3; i++) begin
      int t = 0;
      req_adr = ra[i]; req_dat = 32'ha5a50001; req_we = rw[i]; req_pair = rp[i];
      req_valid = 1'b1;
      while (!req_ready && t < 200) begin @(negedge wb_clk); t++; end
      sb.push_back('{ed[i], 1'b0});
      @(negedge wb_clk);
      if (i == 2) req_valid = 1'b0;
      n_vec++;
      if (req_ready !== 1'b0) begin n_err++; $display("FAIL b2b_busy%0d got ready=%b want 0", i, req_ready); end
    end
    wait_rsps();
    n_vec++;
    if (acc_cnt - a0 !== 3) begin n_err++; $display("FAIL b2b_accepts got %0d want 3", acc_cnt - a0); end
    while (sb.size() > 0) begin
      e = sb.pop_front(); n_vec++;
      if (obs.size() == 0) begin n_err++; $display("FAIL b2b_rsp missing, want dat=%h err=%b", e.dat, e.err); end
      else begin
        o = obs.pop_front(); np++;
        if (o.dat !== e.dat || o.err !== e.err) begin
          n_err++; $display("FAIL b2b_rsp got dat=%h err=%b want dat=%h err=%b", o.dat, o.err, e.dat, e.err);
        end
      end
    end
    n_vec++;
    if (np + obs.size() !== 3) begin n_err++; $display("FAIL b2b_pulses got %0d want 3", np + obs.size()); end
    obs.delete();
  endtask

  task automatic test_wrap();
    rsp_t e, o;
    int t = 0;
    ack_lat = 1;
    issue(32'hfffffffc, 32'h0, 1'b0, 1'b1, 64'h00000000_cafef00d, 1'b1);
    n_vec++;
    if (wb_dbus_adr !== 32'hfffffffc) begin n_err++; $display("FAIL wrap_adr1 got %h want fffffffc", wb_dbus_adr); end
    while (wb_dbus_cyc === 1'b1 && t < 50) begin @(negedge wb_clk); t++; end
    t = 0;
    while (wb_dbus_cyc !== 1'b1 && t < 10) begin @(negedge wb_clk); t++; end
    n_vec++;
    if (wb_dbus_adr !== 32'h00000000 || wb_dbus_cyc !== 1'b1) begin
      n_err++; $display("FAIL wrap_adr2 got adr=%h cyc=%b want 00000000 1", wb_dbus_adr, wb_dbus_cyc);
    end
    wait_rsps();
    while (sb.size() > 0) begin
      e = sb.pop_front(); n_vec++;
      if (obs.size() == 0) begin n_err++; $display("FAIL wrap_rsp missing, want dat=%h err=%b", e.dat, e.err); end
      else begin
        o = obs.pop_front();
        if (o.dat !== e.dat || o.err !== e.err) begin
          n_err++; $display("FAIL wrap_rsp got dat=%h err=%b want dat=%h err=%b", o.dat, o.err, e.dat, e.err);
        end
      end
    end
    repeat (4) @(negedge wb_clk);
    n_vec++;
    if (rsp_dat !== 64'h00000000_cafef00d || rsp_err !== 1'b1) begin
      n_err++; $display("FAIL wrap_hold got dat=%h err=%b want 00000000cafef00d 1", rsp_dat, rsp_err);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_pair();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_wrap();
    n_vec++;
    if (prot_bad !== 0) begin n_err++; $display("FAIL bus_protocol got %0d violations want 0", prot_bad); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
